fp_align_shifter: RTL and testbench
===================================

# fp_align_shifter

Pipelined, bidirectional, parametrised barrel shifter for the floating-point add/sub datapath, used for exponent-difference alignment (right shift) and post-add normalisation (left shift). It extends the single-cycle combinational barrel shifter with:
- a left/right direction input,
- shift-amount clamping,
- sticky-bit and overflow capture,
- a configurable number of pipeline registers,
- a valid/ready handshake with full backpressure.

## Interface
Parameters:
- InputDataWidth, 24, width of data_i.
- OutputDataWidth, 27, width of data_o; must be ≥ InputDataWidth.
- MaxShift, 27, largest shift honoured; larger requests are clamped to MaxShift.
- NumPipe, 2, pipeline register count, range 1..L where L = $clog2(MaxShift+1) shift levels.

Ports:
- clk_i, in, 1, clock; all state updates on rising edge.
- rst_i, in, 1, reset, asynchronous, active-high.
- valid_i, in, 1, input beat valid.
- ready_o, out, 1, block can accept a beat.
- data_i, in, InputDataWidth, operand.
- shift_amount_i, in, $clog2(MaxShift+1), requested shift.
- dir_i, in, 1, 0 = left, 1 = right (shift_dir_e).
- valid_o, out, 1, output beat valid.
- ready_i, in, 1, downstream accepts.
- data_o, out, OutputDataWidth, shifted result.
- sticky_o, out, 1, OR of all nonzero bits shifted out on a right shift.
- overflow_o, out, 1, nonzero bits discarded off the MSB on a left shift.

## Operation
- Effective shift s = min(shift_amount_i, MaxShift), computed at the input stage.
- Left shift:
  - Operand is zero-extended into the LSBs of an OutputDataWidth word, then shifted left by s.
  - Bits leaving the MSB are discarded; overflow_o = 1 if any discarded bit is 1.
  - sticky_o = 0.
- Right shift:
  - Operand is MSB-aligned (data_i << (OutputDataWidth-InputDataWidth)), then logically shifted right by s.
  - sticky_o = OR of every bit shifted below bit 0.
  - overflow_o = 0.
- Shifter structure:
  - L levels, level k shifting by 0 or 2^k.
  - Levels are split across NumPipe register stages as evenly as possible, with the earlier stages taking the extra levels.
  - Each stage register holds the partial word, the remaining shift bits, dir, and the sticky/overflow accumulators.
- Pipeline is elastic:
  - Stage n loads when it is empty or when its contents move forward in the same cycle.
  - ready_o = ~v[0] | ready_of_stage1 (chain ends with ready_i).
  - A beat transfers on valid && ready.
  - Data registers are not reset; valid flags are.

## Timing
- Latency NumPipe cycles from accepted input to valid_o, with no bubbles when ready_i = 1; throughput 1 beat per cycle.
- Reset (rst_i = 1, any time, including mid-stream):
  - All valid flags clear immediately; valid_o = 0, data_o = 0, sticky_o = 0, overflow_o = 0.
  - ready_o = 1 in the first cycle after deassertion.
  - In-flight beats are dropped.
- Backpressure (ready_i = 0):
  - valid_o and all outputs hold stable until the transfer.
  - Upstream stages fill, after which ready_o drops.
  - ready_o is 0 only when all NumPipe stages are valid and ready_i = 0.
- Simultaneous output transfer and input accept with a full pipeline: every stage advances and no beat is lost or duplicated.
- s = 0: data passes through aligned; sticky_o = 0 and overflow_o = 0.
- s ≥ OutputDataWidth: data_o = 0; the flag for the active direction is set iff the operand was nonzero.

## Configuration
- FP_SHIFT_STICKY_EN defined: sticky_o is computed as above and carried through the pipeline.
- FP_SHIFT_STICKY_EN undefined:
  - The sticky accumulator and OR-reduction logic are removed.
  - sticky_o is tied to 0; all other behaviour is identical.

## Structure
- Package fp_shift_pkg holds:
  - typedef enum logic {SHIFT_LEFT = 0, SHIFT_RIGHT = 1} shift_dir_e;
  - function clog2-based level-count helper;
  - stage payload struct (data, remaining shift, dir, sticky, overflow).
- Sub-module fp_shift_stage:
  - Combinational span of shift levels [first, last].
  - Sticky/overflow accumulation for those levels.
  - Instantiated once per pipeline stage by a generate loop; the top level owns the valid/ready registers.

## Test plan
Configuration: InputDataWidth 11, OutputDataWidth 14, MaxShift 15, NumPipe 2.
- Left, data 1200, shift 3 -> data_o 9600, overflow 0, sticky 0, valid_o 2 cycles after accept.
- Left, data 1202, shift 4 -> data_o 2848, overflow 1.
- Right, data 2003, shift 7 -> data_o 125, sticky 1 (FP_SHIFT_STICKY_EN) or sticky 0 (undefined).
- Right, data 999, shift 15 -> data_o 0, sticky 1; data 0, shift 15 -> data_o 0, sticky 0.
- Stream of 8 beats with ready_i toggling 1010… -> all 8 results in order, none lost or duplicated, ready_o low only with both stages full and ready_i = 0.
- Assert rst_i with 2 beats in flight -> valid_o 0 immediately, no stale beats after release, next beat has latency 2.

Source files
------------

// File: rtl/fp_shift_pkg.sv
// ---------------------------------------------------------------------------
// fp_shift_pkg
// Shared types and elaboration helpers for the floating-point alignment /
// normalisation barrel shifter (fp_align_shifter, fp_shift_stage).
//
// Contents:
//   shift_dir_e        - shift direction (0 = left, 1 = right)
//   stage_flags_t      - per-beat control/flag part of the stage payload
//                        (direction, sticky accumulator, overflow accumulator)
//   num_levels()       - number of binary shift levels for a given max shift
//   stage_first_level()/stage_last_level()
//                      - span of levels handled by one pipeline stage; levels
//                        are split as evenly as possible, earlier stages take
//                        the remainder
//
// The width-dependent part of the stage payload (data word and remaining
// shift bits) depends on the shifter's parameters, so the full payload struct
// is declared inside fp_align_shifter and embeds stage_flags_t from here.
// ---------------------------------------------------------------------------
package fp_shift_pkg;

    typedef enum logic {
        SHIFT_LEFT  = 1'b0,
        SHIFT_RIGHT = 1'b1
    } shift_dir_e;

    typedef struct packed {
        shift_dir_e dir;
        logic       sticky;
        logic       overflow;
    } stage_flags_t;

    // A shifter that must honour shifts up to max_shift needs one level per
    // bit of the shift amount.
    function automatic int num_levels(input int max_shift);
        return (max_shift < 1) ? 1 : $clog2(max_shift + 1);
    endfunction

    function automatic int stage_first_level(input int stage, input int levels,
                                             input int stages);
        int base;
        int extra;
        base  = levels / stages;
        extra = levels % stages;
        return stage * base + ((stage < extra) ? stage : extra);
    endfunction

    function automatic int stage_last_level(input int stage, input int levels,
                                            input int stages);
        int base;
        int extra;
        base  = levels / stages;
        extra = levels % stages;
        return stage_first_level(stage, levels, stages) + base
               + ((stage < extra) ? 1 : 0) - 1;
    endfunction

endpackage

// File: rtl/fp_shift_stage.sv
// ---------------------------------------------------------------------------
// fp_shift_stage
// Combinational span of barrel-shifter levels [FirstLevel, LastLevel].
// Level k shifts the word by 0 or 2^k positions depending on bit k of the
// remaining shift amount. While shifting, the stage accumulates:
//   - overflow: any 1 bit pushed off the MSB on a left shift
//   - sticky  : any 1 bit pushed below bit 0 on a right shift
// Consumed shift bits are cleared so the payload carries only what remains.
//
// Build option: FP_SHIFT_STICKY_EN
//   defined   - sticky accumulation is implemented
//   undefined - sticky logic is removed and flags_next.sticky is always 0
//
// Ports:
//   data        in   DataWidth   partial word entering this span
//   shift       in   ShiftWidth  remaining shift bits
//   flags       in   stage_flags_t direction and accumulated flags
//   data_next   out  DataWidth   word after this span
//   shift_next  out  ShiftWidth  remaining shift with this span's bits cleared
//   flags_next  out  stage_flags_t updated flags
// ---------------------------------------------------------------------------
module fp_shift_stage
    import fp_shift_pkg::*;
#(
    parameter int DataWidth  = 27,
    parameter int ShiftWidth = 5,
    parameter int FirstLevel = 0,
    parameter int LastLevel  = 0
) (
    input  logic [DataWidth-1:0]  data,
    input  logic [ShiftWidth-1:0] shift,
    input  stage_flags_t          flags,
    output logic [DataWidth-1:0]  data_next,
    output logic [ShiftWidth-1:0] shift_next,
    output stage_flags_t          flags_next
);

    localparam logic [DataWidth-1:0] AllOnes = {DataWidth{1'b1}};

    logic [DataWidth-1:0]  word;
    logic [ShiftWidth-1:0] rem;
    stage_flags_t          acc;

    always_comb begin
        word = data;
        rem  = shift;
        acc  = flags;
        for (int k = FirstLevel; k <= LastLevel; k++) begin
            if (shift[k]) begin
                if (flags.dir == SHIFT_RIGHT) begin
`ifdef FP_SHIFT_STICKY_EN
                    // Low 2^k bits are about to fall below bit 0.
                    acc.sticky = acc.sticky | (|(word & ~(AllOnes << (1 << k))));
`endif
                    word = word >> (1 << k);
                end else begin
                    // High 2^k bits are about to fall off the MSB.
                    acc.overflow = acc.overflow | (|(word & ~(AllOnes >> (1 << k))));
                    word = word << (1 << k);
                end
            end
            rem[k] = 1'b0;
        end
`ifndef FP_SHIFT_STICKY_EN
        acc.sticky = 1'b0;
`endif
        data_next  = word;
        shift_next = rem;
        flags_next = acc;
    end

endmodule

// File: rtl/fp_align_shifter.sv
// ---------------------------------------------------------------------------
// fp_align_shifter
// Pipelined bidirectional barrel shifter for the FP add/sub datapath:
// right shift for exponent-difference alignment (with sticky capture) and
// left shift for post-add normalisation (with overflow capture).
//
// The shift amount is clamped to MaxShift at the input. A left shift places
// the operand in the LSBs of the output word; a right shift MSB-aligns it
// first. The L = clog2(MaxShift+1) shift levels are spread over NumPipe
// register stages (earlier stages take any extra level). The pipeline is
// elastic: a stage loads when it is empty or its contents move on in the
// same cycle, so there are no bubbles and full backpressure is supported.
// Data registers are not reset; only the valid flags are. Outputs are forced
// to zero whenever valid_o is low.
//
// Build option: FP_SHIFT_STICKY_EN
//   defined   - sticky_o reports bits shifted out on right shifts
//   undefined - sticky logic is removed and sticky_o is tied to 0
//
// Parameters:
//   InputDataWidth  width of data_i
//   OutputDataWidth width of data_o (>= InputDataWidth)
//   MaxShift        largest honoured shift, larger requests are clamped
//   NumPipe         register stages, 1..clog2(MaxShift+1)
//
// Ports:
//   clk_i           in   1     clock, rising edge
//   rst_i           in   1     asynchronous active-high reset
//   valid_i         in   1     input beat valid
//   ready_o         out  1     block can accept a beat
//   data_i          in   IW    operand
//   shift_amount_i  in   SW    requested shift
//   dir_i           in   1     0 = left, 1 = right
//   valid_o         out  1     output beat valid
//   ready_i         in   1     downstream accepts
//   data_o          out  OW    shifted result
//   sticky_o        out  1     nonzero bits lost below bit 0 (right shift)
//   overflow_o      out  1     nonzero bits lost off the MSB (left shift)
// ---------------------------------------------------------------------------
module fp_align_shifter
    import fp_shift_pkg::*;
#(
    parameter int InputDataWidth  = 24,
    parameter int OutputDataWidth = 27,
    parameter int MaxShift        = 27,
    parameter int NumPipe         = 2
) (
    input  logic                           clk_i,
    input  logic                           rst_i,
    input  logic                           valid_i,
    output logic                           ready_o,
    input  logic [InputDataWidth-1:0]      data_i,
    input  logic [$clog2(MaxShift+1)-1:0]  shift_amount_i,
    input  logic                           dir_i,
    output logic                           valid_o,
    input  logic                           ready_i,
    output logic [OutputDataWidth-1:0]     data_o,
    output logic                           sticky_o,
    output logic                           overflow_o
);

    localparam int ShiftWidth = $clog2(MaxShift + 1);
    localparam int Levels     = num_levels(MaxShift);
    localparam int Last       = NumPipe - 1;

    if (OutputDataWidth < InputDataWidth) begin : g_bad_width
        $error("fp_align_shifter: OutputDataWidth must be >= InputDataWidth");
    end
    if (NumPipe < 1 || NumPipe > Levels) begin : g_bad_pipe
        $error("fp_align_shifter: NumPipe must be in 1..clog2(MaxShift+1)");
    end

    typedef struct packed {
        logic [OutputDataWidth-1:0] data;
        logic [ShiftWidth-1:0]      shift;
        stage_flags_t               flags;
    } payload_t;

    payload_t in_payload;
    payload_t stage_in   [NumPipe];
    payload_t stage_next [NumPipe];
    payload_t stage_q    [NumPipe];

    logic [OutputDataWidth-1:0] next_data  [NumPipe];
    logic [ShiftWidth-1:0]      next_shift [NumPipe];
    stage_flags_t               next_flags [NumPipe];

    logic [NumPipe-1:0] stage_valid;
    logic [NumPipe-1:0] stage_ready;
    logic [NumPipe-1:0] stage_feed;

    // Input stage: clamp, align and seed the flag accumulators.
    always_comb begin
        in_payload           = '0;
        in_payload.flags.dir = shift_dir_e'(dir_i);
        if (int'(shift_amount_i) > MaxShift) begin
            in_payload.shift = ShiftWidth'(MaxShift);
        end else begin
            in_payload.shift = shift_amount_i;
        end
        if (in_payload.flags.dir == SHIFT_RIGHT) begin
            in_payload.data = OutputDataWidth'(data_i) << (OutputDataWidth - InputDataWidth);
        end else begin
            in_payload.data = OutputDataWidth'(data_i);
        end
    end

    always_comb begin
        stage_in[0] = in_payload;
        for (int n = 1; n < NumPipe; n++) begin
            stage_in[n] = stage_q[n-1];
        end
    end

    for (genvar n = 0; n < NumPipe; n++) begin : g_stage
        fp_shift_stage #(
            .DataWidth  (OutputDataWidth),
            .ShiftWidth (ShiftWidth),
            .FirstLevel (stage_first_level(n, Levels, NumPipe)),
            .LastLevel  (stage_last_level(n, Levels, NumPipe))
        ) u_stage (
            .data       (stage_in[n].data),
            .shift      (stage_in[n].shift),
            .flags      (stage_in[n].flags),
            .data_next  (next_data[n]),
            .shift_next (next_shift[n]),
            .flags_next (next_flags[n])
        );
    end

    always_comb begin
        for (int n = 0; n < NumPipe; n++) begin
            stage_next[n].data  = next_data[n];
            stage_next[n].shift = next_shift[n];
            stage_next[n].flags = next_flags[n];
        end
    end

    // Ready ripples back from the output: a stage can take a beat when it is
    // empty or its current beat leaves in the same cycle.
    always_comb begin
        stage_ready[Last] = ~stage_valid[Last] | ready_i;
        for (int n = Last - 1; n >= 0; n--) begin
            stage_ready[n] = ~stage_valid[n] | stage_ready[n+1];
        end
    end

    always_comb begin
        stage_feed[0] = valid_i;
        for (int n = 1; n < NumPipe; n++) begin
            stage_feed[n] = stage_valid[n-1];
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            stage_valid <= '0;
        end else begin
            for (int n = 0; n < NumPipe; n++) begin
                if (stage_ready[n]) begin
                    stage_valid[n] <= stage_feed[n];
                end
            end
        end
    end

    always_ff @(posedge clk_i) begin
        for (int n = 0; n < NumPipe; n++) begin
            if (stage_ready[n] && stage_feed[n]) begin
                stage_q[n] <= stage_next[n];
            end
        end
    end

    assign ready_o = stage_ready[0];
    assign valid_o = stage_valid[Last];

    // Data registers are never reset, so outputs are masked by valid_o.
    always_comb begin
        data_o     = valid_o ? stage_q[Last].data : '0;
        overflow_o = valid_o & stage_q[Last].flags.overflow;
`ifdef FP_SHIFT_STICKY_EN
        sticky_o   = valid_o & stage_q[Last].flags.sticky;
`else
        sticky_o   = 1'b0;
`endif
    end

endmodule

// File: tb/tb_fp_align_shifter.sv
module tb_fp_align_shifter;

    localparam int IW = 11;
    localparam int OW = 14;
    localparam int MS = 15;
    localparam int NP = 2;
    localparam int SW = $clog2(MS + 1);

`ifdef FP_SHIFT_STICKY_EN
    localparam logic STK = 1'b1;
`else
    localparam logic STK = 1'b0;
`endif

    logic          clk_i = 1'b0;
    logic          rst_i;
    logic          valid_i;
    logic          ready_o;
    logic [IW-1:0] data_i;
    logic [SW-1:0] shift_amount_i;
    logic          dir_i;
    logic          valid_o;
    logic          ready_i;
    logic [OW-1:0] data_o;
    logic          sticky_o;
    logic          overflow_o;

    fp_align_shifter #(
        .InputDataWidth  (IW),
        .OutputDataWidth (OW),
        .MaxShift        (MS),
        .NumPipe         (NP)
    ) dut (
        .clk_i          (clk_i),
        .rst_i          (rst_i),
        .valid_i        (valid_i),
        .ready_o        (ready_o),
        .data_i         (data_i),
        .shift_amount_i (shift_amount_i),
        .dir_i          (dir_i),
        .valid_o        (valid_o),
        .ready_i        (ready_i),
        .data_o         (data_o),
        .sticky_o       (sticky_o),
        .overflow_o     (overflow_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic [OW-1:0] data;
        logic          sticky;
        logic          ovf;
        bit            lat;
        int            acc_cyc;
        int            id;
    } exp_t;

    exp_t sb[$];
    int   checks   = 0;
    int   failures = 0;
    int   cyc      = 0;
    int   acc_cnt  = 0;
    int   out_cnt  = 0;
    int   next_id  = 0;
    bit   chk_en   = 1'b0;

    always @(posedge clk_i) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d (t=%0t)", name, act, req, $time);
        end
    endtask

    // Drive one beat and hold it until accepted; push the expected result.
    task automatic send(input logic [IW-1:0] d, input logic [SW-1:0] s, input logic dr,
                        input logic [OW-1:0] ed, input logic es, input logic eo, input bit lat);
        exp_t e;
        int   waited;
        bit   done;
        waited = 0;
        done   = 1'b0;
        @(posedge clk_i);
        #2;
        valid_i        = 1'b1;
        data_i         = d;
        shift_amount_i = s;
        dir_i          = dr;
        while (!done) begin
            @(negedge clk_i);
            if (ready_o) begin
                e.data    = ed;
                e.sticky  = es;
                e.ovf     = eo;
                e.lat     = lat;
                e.acc_cyc = cyc;
                e.id      = next_id;
                next_id++;
                sb.push_back(e);
                acc_cnt++;
                done = 1'b1;
            end else begin
                waited++;
                if (waited > 50) begin
                    check("accept_timeout", 32'(waited), 32'd0);
                    done = 1'b1;
                end
            end
        end
    endtask

    task automatic idle();
        @(posedge clk_i);
        #2;
        valid_i = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 100) begin
            @(negedge clk_i);
            n++;
        end
        check("drain_timeout", 32'(sb.size()), 32'd0);
    endtask

    // Monitor: pops and compares on every output transfer; also checks that a
    // stalled output holds still.
    initial begin : monitor
        exp_t          e;
        bit            stall_prev;
        logic [OW-1:0] held_data;
        logic          held_stk;
        logic          held_ovf;
        stall_prev = 1'b0;
        held_data  = '0;
        held_stk   = 1'b0;
        held_ovf   = 1'b0;
        forever begin
            @(negedge clk_i);
            if (rst_i) begin
                stall_prev = 1'b0;
            end else begin
                if (stall_prev) begin
                    check("hold_valid", 32'(valid_o), 32'd1);
                    if (valid_o) begin
                        check("hold_data", 32'(data_o), 32'(held_data));
                        check("hold_sticky", 32'(sticky_o), 32'(held_stk));
                        check("hold_overflow", 32'(overflow_o), 32'(held_ovf));
                    end
                end
                if (valid_o && ready_i) begin
                    stall_prev = 1'b0;
                    out_cnt++;
                    if (sb.size() == 0) begin
                        checks++;
                        failures++;
                        $display("FAIL unexpected_beat actual data=%0d required=no beat", data_o);
                    end else begin
                        e = sb.pop_front();
                        check($sformatf("data[%0d]", e.id), 32'(data_o), 32'(e.data));
                        check($sformatf("sticky[%0d]", e.id), 32'(sticky_o), 32'(e.sticky));
                        check($sformatf("overflow[%0d]", e.id), 32'(overflow_o), 32'(e.ovf));
                        if (e.lat) check($sformatf("latency[%0d]", e.id), 32'(cyc - e.acc_cyc), 32'(NP));
                    end
                end else if (valid_o) begin
                    stall_prev = 1'b1;
                    held_data  = data_o;
                    held_stk   = sticky_o;
                    held_ovf   = overflow_o;
                end else begin
                    stall_prev = 1'b0;
                end
            end
        end
    end

    // ready_o must be low exactly when every stage holds a beat and ready_i=0.
    initial begin : ready_checker
        int snap;
        forever begin
            @(posedge clk_i);
            #1;
            snap = acc_cnt - out_cnt;
            @(negedge clk_i);
            if (chk_en) check("ready_o", 32'(ready_o), 32'(!(snap == NP && !ready_i)));
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

    initial begin : stimulus
        rst_i          = 1'b1;
        valid_i        = 1'b0;
        data_i         = '0;
        shift_amount_i = '0;
        dir_i          = 1'b0;
        ready_i        = 1'b1;

        repeat (2) @(posedge clk_i);
        #1;
        check("rst_valid_o", 32'(valid_o), 32'd0);
        check("rst_data_o", 32'(data_o), 32'd0);
        check("rst_sticky_o", 32'(sticky_o), 32'd0);
        check("rst_overflow_o", 32'(overflow_o), 32'd0);
        @(posedge clk_i);
        #2;
        rst_i = 1'b0;
        @(negedge clk_i);
        check("ready_after_reset", 32'(ready_o), 32'd1);
        chk_en = 1'b1;

        // Directed vectors, back to back with ready_i=1 (latency checked).
        send(11'd1200, 4'd3,  1'b0, 14'd9600,  1'b0, 1'b0, 1'b1);
        send(11'd1202, 4'd4,  1'b0, 14'd2848,  1'b0, 1'b1, 1'b1);
        send(11'd2003, 4'd7,  1'b1, 14'd125,   STK,  1'b0, 1'b1);
        send(11'd999,  4'd15, 1'b1, 14'd0,     STK,  1'b0, 1'b1);
        send(11'd0,    4'd15, 1'b1, 14'd0,     1'b0, 1'b0, 1'b1);
        send(11'd1200, 4'd0,  1'b0, 14'd1200,  1'b0, 1'b0, 1'b1);
        send(11'd2047, 4'd0,  1'b1, 14'd16376, 1'b0, 1'b0, 1'b1);
        send(11'd999,  4'd15, 1'b0, 14'd0,     1'b0, 1'b1, 1'b1);
        send(11'd0,    4'd15, 1'b0, 14'd0,     1'b0, 1'b0, 1'b1);
        send(11'd1,    4'd13, 1'b0, 14'd8192,  1'b0, 1'b0, 1'b1);
        send(11'd1,    4'd14, 1'b0, 14'd0,     1'b0, 1'b1, 1'b1);
        send(11'd999,  4'd14, 1'b1, 14'd0,     STK,  1'b0, 1'b1);
        idle();
        drain();

        // Stream of 8 beats with ready_i toggling every cycle.
        fork
            begin
                send(11'd1,    4'd1, 1'b0, 14'd2,     1'b0, 1'b0, 1'b0);
                send(11'd1024, 4'd2, 1'b1, 14'd2048,  1'b0, 1'b0, 1'b0);
                send(11'd2047, 4'd3, 1'b0, 14'd16376, 1'b0, 1'b0, 1'b0);
                send(11'd5,    4'd1, 1'b1, 14'd20,    1'b0, 1'b0, 1'b0);
                send(11'd2047, 4'd4, 1'b0, 14'd16368, 1'b0, 1'b1, 1'b0);
                send(11'd3,    4'd4, 1'b1, 14'd1,     STK,  1'b0, 1'b0);
                send(11'd100,  4'd0, 1'b0, 14'd100,   1'b0, 1'b0, 1'b0);
                send(11'd1,    4'd3, 1'b1, 14'd1,     1'b0, 1'b0, 1'b0);
                idle();
            end
            begin
                repeat (24) begin
                    @(posedge clk_i);
                    #2;
                    ready_i = ~ready_i;
                end
                @(posedge clk_i);
                #2;
                ready_i = 1'b1;
            end
        join
        drain();
        check("stream_count", 32'(out_cnt), 32'(acc_cnt));

        // Reset with two beats in flight (pipeline full, output stalled).
        @(posedge clk_i);
        #2;
        ready_i = 1'b0;
        send(11'd7, 4'd1, 1'b0, 14'd14, 1'b0, 1'b0, 1'b0);
        send(11'd9, 4'd2, 1'b0, 14'd36, 1'b0, 1'b0, 1'b0);
        idle();
        @(negedge clk_i);
        check("full_before_reset_valid_o", 32'(valid_o), 32'd1);
        check("full_before_reset_ready_o", 32'(ready_o), 32'd0);
        chk_en = 1'b0;
        @(posedge clk_i);
        #2;
        rst_i = 1'b1;
        #1;
        check("midrst_valid_o", 32'(valid_o), 32'd0);
        check("midrst_data_o", 32'(data_o), 32'd0);
        check("midrst_overflow_o", 32'(overflow_o), 32'd0);
        check("midrst_sticky_o", 32'(sticky_o), 32'd0);
        sb.delete();
        acc_cnt = 0;
        out_cnt = 0;
        repeat (2) @(posedge clk_i);
        #2;
        rst_i   = 1'b0;
        ready_i = 1'b1;
        @(negedge clk_i);
        check("ready_after_midrst", 32'(ready_o), 32'd1);
        chk_en = 1'b1;
        repeat (4) @(negedge clk_i);
        check("no_stale_beats", 32'(out_cnt), 32'd0);
        send(11'd1200, 4'd3, 1'b0, 14'd9600, 1'b0, 1'b0, 1'b1);
        idle();
        drain();

        repeat (3) @(negedge clk_i);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
